mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM stage of the 5-stage RV32I core. It consumes the EX/MEM register, which carries EX
//  results for instructions issued from the ID/EX register. Loads and stores run byte-serially
//  over the 8-bit memory port, little-endian. The stage raises stall_req until the access ends,
//  then presents the write-back data to the MEM/WB register.
// PARAMETERS
//  ADDR_W  32  byte-address width; address arithmetic wraps modulo 2^ADDR_W
//  REG_W   32  register/data width; fixed at 32 for RV32I
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, synchronous, active-high
//  mem_en      in   1       EX/MEM instruction is a load/store
//  mem_we      in   1       1=store, 0=load
//  mem_funct3  in   3       LB000 LH001 LW010 LBU100 LHU101; SB000 SH001 SW010
//  mem_addr    in   ADDR_W  effective address
//  mem_sdata   in   REG_W   store data (rs2)
//  alu_result  in   REG_W   EX result for non-memory instructions
//  wd_i        in   5       destination register
//  wreg_i      in   1       write-enable of destination
//  ram_req     out  1       byte request valid
//  ram_wr      out  1       1=write byte, 0=read byte
//  ram_a       out  ADDR_W  byte address
//  ram_dout    out  8       write byte
//  ram_gnt     in   1       arbiter accepted request this cycle
//  ram_din     in   8       read byte, valid exactly 1 cycle after its request was granted
//  stall_req   out  1       hold stages 0..4 (feeds stall_state)
//  wb_wd       out  5       to MEM/WB
//  wb_wreg     out  1       to MEM/WB
//  wb_wdata    out  REG_W   to MEM/WB
// BEHAVIOUR
//  - rst high: state<=IDLE, cnt<=0, buffers<=0. All outputs are forced 0 combinationally while
//    rst is high. An access aborts mid-operation with no further ram_req.
//  - Size: funct3[1:0] 00->1 byte, 01->2 bytes, 10->4 bytes. funct3[1:0]=11 is treated as 4.
//    Misaligned addresses are legal.
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - IDLE, mem_en=0: pass-through. wb_wdata=alu_result, wb_wd/wb_wreg=inputs, stall_req=0.
//  - IDLE, mem_en=1: stall_req=1 combinationally.
//      latch addr, sdata, funct3, we; cnt<=0; ->REQ.
//  - REQ:
//      ram_req=1, ram_wr=we_q, ram_a=addr_q+cnt (wraps), ram_dout=sdata_q[8*cnt+:8].
//      on ram_gnt: cnt<=cnt+1.
//      on ram_gnt with a read: next cycle captures ram_din into rbuf[idx], idx=granted cnt.
//        Capture happens even if gnt drops that cycle.
//      last byte granted: store ->DONE; load ->WAIT.
//      gnt=0: hold all outputs stable, no timeout.
//  - WAIT: capture final read byte; ->DONE; stall_req=1.
//  - DONE: stall_req=0, ram_req=0. ->IDLE.
//      load: wb_wdata = rbuf sign-extended (LB/LH) or zero-extended (LBU/LHU).
//      store: wb_wdata=alu_result, wb_wreg=wreg_i (=0).
//  - stall_req=1 in every cycle except IDLE with mem_en=0, and DONE.
//  - Latency with ram_gnt tied high: access of N bytes stalls 1+N (store) or 2+N (load) cycles.
//    Result appears in the DONE cycle.
//  - The next instruction is sampled only in IDLE, so back-to-back accesses never overlap.
//    The pipeline advances at the end of DONE, so IDLE sees the new EX/MEM contents.
// TESTING
//  1 LW @0x100, mem=11 22 33 44, gnt=1 -> stall 6 cycles; ram_a 100..103; DONE wb_wdata=0x44332211.
//  2 LB @0x80 byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LH bytes 34 F2 -> 0xFFFFF234.
//  3 SH @0x2, sdata=0xABCD1234 -> writes 0x34@0x2, 0x12@0x3 only; stall 3 cycles; wb_wreg=0.
//  4 LW with gnt low 3 cycles before byte1 -> ram_a/ram_req stable while waiting; result correct.
//  5 LH @0xFFFFFFFF -> second byte at 0x00000000 (wrap); rst asserted mid-LW -> next cycle all outputs 0, IDLE.
//  6 ADD (mem_en=0) between two LWs -> no stall, wb_wdata=alu_result same cycle; LWs complete independently.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: byte-serial little-endian loads/stores over an 8-bit arbitrated port,
// stalling the pipeline until the access completes and then presenting write-back data.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [REG_W-1:0]  mem_sdata,
  input  logic [REG_W-1:0]  alu_result,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic              ram_gnt,
  input  logic [7:0]        ram_din,
  output logic              stall_req,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [REG_W-1:0]   r_sdata;
  logic [2:0]         r_f3;
  logic               r_we;
  logic               r_rd_pend;
  logic [1:0]         r_rd_idx;
  logic [7:0]         r_rbuf [4];

  logic [1:0]         w_last_idx;
  logic               w_last;
  logic [4:0]         w_byte_sel;
  logic [31:0]        w_load_data;

  // Size code 11 is treated as a word access.
  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  assign w_last     = (r_cnt[1:0] == w_last_idx);
  assign w_byte_sel = {r_cnt[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_addr    <= '0;
      r_sdata   <= '0;
      r_f3      <= 3'd0;
      r_we      <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 2'd0;
    end else begin
      r_rd_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_en) begin
            r_addr  <= mem_addr;
            r_sdata <= mem_sdata;
            r_f3    <= mem_funct3;
            r_we    <= mem_we;
            r_cnt   <= 3'd0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (ram_gnt) begin
            r_cnt <= r_cnt + 3'd1;
            if (!r_we) begin
              r_rd_pend <= 1'b1;
              r_rd_idx  <= r_cnt[1:0];
            end
            if (w_last) begin
              r_state <= r_we ? S_DONE : S_WAIT;
            end
          end
        end
        S_WAIT:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its grant; each lane captures its own byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rbuf
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rbuf[gi] <= 8'd0;
      end else if (r_rd_pend && (r_rd_idx == 2'(gi))) begin
        r_rbuf[gi] <= ram_din;
      end
    end
  end

  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_load_data = {{24{~r_f3[2] & r_rbuf[0][7]}}, r_rbuf[0]};
      2'b01:   w_load_data = {{16{~r_f3[2] & r_rbuf[1][7]}}, r_rbuf[1], r_rbuf[0]};
      default: w_load_data = {r_rbuf[3], r_rbuf[2], r_rbuf[1], r_rbuf[0]};
    endcase
  end

  // Write-back is suppressed while stalled so no stale result can be committed.
  always_comb begin
    ram_req   = 1'b0;
    ram_wr    = 1'b0;
    ram_a     = '0;
    ram_dout  = 8'd0;
    stall_req = 1'b0;
    wb_wd     = 5'd0;
    wb_wreg   = 1'b0;
    wb_wdata  = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          stall_req = mem_en;
          if (!mem_en) begin
            wb_wd    = wd_i;
            wb_wreg  = wreg_i;
            wb_wdata = alu_result;
          end
        end
        S_REQ: begin
          stall_req = 1'b1;
          ram_req   = 1'b1;
          ram_wr    = r_we;
          ram_a     = r_addr + ADDR_W'(r_cnt);
          ram_dout  = r_sdata[w_byte_sel +: 8];
        end
        S_WAIT: stall_req = 1'b1;
        default: begin
          wb_wd    = wd_i;
          wb_wreg  = wreg_i;
          wb_wdata = r_we ? alu_result : w_load_data;
        end
      endcase
    end
  end

endmodule
